// File: rtl/quant_sched.sv
// quant_sched: round-robin front end for one shared module_quant datapath.
// Grants one accumulator per cycle, drives the channel's scale/shift/zero_point
// alongside it, follows the datapath latency with a tag pipe and buffers the
// int4 results in a small FIFO. Credit covers tags plus FIFO entries, so the
// FIFO cannot overflow even when the consumer stalls.
module quant_sched #(
   parameter int NREQ  = 4,
   parameter int CH_W  = 2,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [CH_W-1:0]      cfg_addr,
   input  logic [15:0]          cfg_scale,
   input  logic [3:0]           cfg_shift,
   input  logic [3:0]           cfg_zp,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*15-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 flush,
   output logic [14:0]          q_acc,
   output logic [15:0]          q_scale,
   output logic [3:0]           q_shift,
   output logic [3:0]           q_zp,
   input  logic [3:0]           q_result,
   output logic                 out_valid,
   output logic [3:0]           out_data,
   output logic [CH_W-1:0]      out_ch,
   input  logic                 out_ready,
   output logic                 busy
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int INF_W = $clog2(DEPTH + LAT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [15:0]       tbl_scale_q [NREQ];
   logic [15:0]       tbl_scale_d [NREQ];
   logic [3:0]        tbl_shift_q [NREQ];
   logic [3:0]        tbl_shift_d [NREQ];
   logic [3:0]        tbl_zp_q [NREQ];
   logic [3:0]        tbl_zp_d [NREQ];
   logic [14:0]       q_acc_q, q_acc_d;
   logic [15:0]       q_scale_q, q_scale_d;
   logic [3:0]        q_shift_q, q_shift_d;
   logic [3:0]        q_zp_q, q_zp_d;
   logic [LAT-1:0]    tag_vld_q, tag_vld_d;
   logic [CH_W-1:0]   tag_ch_q [LAT];
   logic [CH_W-1:0]   tag_ch_d [LAT];
   logic [3:0]        fifo_data_q [DEPTH];
   logic [3:0]        fifo_data_d [DEPTH];
   logic [CH_W-1:0]   fifo_ch_q [DEPTH];
   logic [CH_W-1:0]   fifo_ch_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [14:0]       req_acc [NREQ];
   logic [CH_W-1:0]   arb_idx [NREQ];
   logic [NREQ-1:0]   grant;
   logic              grant_any;
   logic [CH_W-1:0]   grant_ch;
   logic [INF_W-1:0]  inflight;
   logic              issue_ok;
   logic              push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Unpack the accumulator bus and precompute the search order from the pointer.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_acc[gi] = req_data[15*gi +: 15];
         assign arb_idx[gi] = CH_W'((int'(rr_q) + gi) % NREQ);
      end
   endgenerate

   // Results still owed to the FIFO: tags in the pipe plus stored entries.
   always_comb begin
      inflight = INF_W'(cnt_q);
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + INF_W'(tag_vld_q[i]);
      end
   end

   assign issue_ok = (inflight < INF_W'(DEPTH)) && (state_q != FLUSH);

   // Round-robin search: first valid requester at or after the pointer.
   always_comb begin
      grant_any = 1'b0;
      grant_ch  = '0;
      grant     = '0;
      if (issue_ok) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[arb_idx[i]]) begin
               grant_any = 1'b1;
               grant_ch  = arb_idx[i];
            end
         end
      end
      if (grant_any) begin
         grant[grant_ch] = 1'b1;
      end
   end

   // Nothing may transfer while reset is held, even though the pipe looks empty.
   assign req_ready = rst ? '0 : grant;

   // Parameter table write; an issue in the same cycle still sees the old entry.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         tbl_scale_d[i] = tbl_scale_q[i];
         tbl_shift_d[i] = tbl_shift_q[i];
         tbl_zp_d[i]    = tbl_zp_q[i];
      end
      if (cfg_we) begin
         tbl_scale_d[cfg_addr] = cfg_scale;
         tbl_shift_d[cfg_addr] = cfg_shift;
         tbl_zp_d[cfg_addr]    = cfg_zp;
      end
   end

   // Issue register: operands for module_quant, held when nothing is granted.
   always_comb begin
      q_acc_d   = q_acc_q;
      q_scale_d = q_scale_q;
      q_shift_d = q_shift_q;
      q_zp_d    = q_zp_q;
      rr_d      = rr_q;
      if (grant_any) begin
         q_acc_d   = req_acc[grant_ch];
         q_scale_d = tbl_scale_q[grant_ch];
         q_shift_d = tbl_shift_q[grant_ch];
         q_zp_d    = tbl_zp_q[grant_ch];
         rr_d      = (grant_ch == CH_W'(NREQ - 1)) ? '0 : grant_ch + 1'b1;
      end
   end

   // Tag pipe: the last stage lines up with q_result from the datapath.
   always_comb begin
      tag_vld_d = '0;
      for (int i = 0; i < LAT; i++) begin
         tag_ch_d[i] = '0;
      end
      tag_vld_d[0] = grant_any;
      tag_ch_d[0]  = grant_ch;
      for (int i = 1; i < LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_ch_d[i]  = tag_ch_q[i-1];
      end
   end

   assign push      = tag_vld_q[LAT-1];
   assign out_valid = (cnt_q != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = fifo_data_q[rd_ptr_q];
   assign out_ch    = fifo_ch_q[rd_ptr_q];

   // Output FIFO: capture on tag exit, pop on handshake.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         fifo_data_d[i] = fifo_data_q[i];
         fifo_ch_d[i]   = fifo_ch_q[i];
      end
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         fifo_data_d[wr_ptr_q] = q_result;
         fifo_ch_d[wr_ptr_q]   = tag_ch_q[LAT-1];
         wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Control FSM: FLUSH blocks grants but lets everything in flight drain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_any) state_d = RUN;
         RUN: begin
            if (flush) begin
               state_d = FLUSH;
            end else if (inflight == '0 && !grant_any) begin
               state_d = IDLE;
            end
         end
         FLUSH:   if (inflight == '0 && !flush) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign q_acc   = q_acc_q;
   assign q_scale = q_scale_q;
   assign q_shift = q_shift_q;
   assign q_zp    = q_zp_q;

   // State registers; reset drops anything in flight immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         q_acc_q   <= '0;
         q_scale_q <= '0;
         q_shift_q <= '0;
         q_zp_q    <= '0;
         tag_vld_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < NREQ; i++) begin
            tbl_scale_q[i] <= '0;
            tbl_shift_q[i] <= '0;
            tbl_zp_q[i]    <= '0;
         end
         for (int i = 0; i < LAT; i++) begin
            tag_ch_q[i] <= '0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_ch_q[i]   <= '0;
         end
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         q_acc_q   <= q_acc_d;
         q_scale_q <= q_scale_d;
         q_shift_q <= q_shift_d;
         q_zp_q    <= q_zp_d;
         tag_vld_q <= tag_vld_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         for (int i = 0; i < NREQ; i++) begin
            tbl_scale_q[i] <= tbl_scale_d[i];
            tbl_shift_q[i] <= tbl_shift_d[i];
            tbl_zp_q[i]    <= tbl_zp_d[i];
         end
         for (int i = 0; i < LAT; i++) begin
            tag_ch_q[i] <= tag_ch_d[i];
         end
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_q[i] <= fifo_data_d[i];
            fifo_ch_q[i]   <= fifo_ch_d[i];
         end
      end
   end
endmodule

// File: tb/tb_quant_sched.sv
// Directed bench for quant_sched with a behavioural module_quant stand-in.
// Results are logged as {ch, data} bytes (ch in the upper hex digit).
module tb_quant_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_scale;
   logic [3:0]  cfg_shift;
   logic [3:0]  cfg_zp;
   logic [3:0]  req_valid;
   logic [59:0] req_data;
   logic [3:0]  req_ready;
   logic        flush;
   logic [14:0] q_acc;
   logic [15:0] q_scale;
   logic [3:0]  q_shift;
   logic [3:0]  q_zp;
   logic [3:0]  q_result;
   logic        out_valid;
   logic [3:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_ready;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   logic [5:0] got_q[$];

   quant_sched #(.NREQ(4), .CH_W(2), .LAT(2), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale),
      .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .flush(flush),
      .q_acc(q_acc), .q_scale(q_scale), .q_shift(q_shift), .q_zp(q_zp),
      .q_result(q_result),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // module_quant stand-in: scale, arithmetic shift, int4 saturate, add zero point.
   function automatic logic [3:0] quant_ref(input logic signed [14:0] acc,
                                            input logic signed [15:0] sc,
                                            input logic [3:0] sh,
                                            input logic [3:0] zp);
      logic signed [30:0] prod;
      logic signed [30:0] shr;
      logic signed [3:0]  sat;
      prod = acc * sc;
      shr  = prod >>> sh;
      if (shr > 31'sd7)       sat = 4'sd7;
      else if (shr < -31'sd8) sat = -4'sd8;
      else                    sat = shr[3:0];
      return sat + zp;
   endfunction

   // Operands appear the cycle after the grant, result one cycle after that.
   logic [3:0] mq_s1 = 4'h0;
   always @(posedge clk) mq_s1 <= quant_ref($signed(q_acc), $signed(q_scale), q_shift, q_zp);
   assign q_result = mq_s1;

   // Record every popped result, one line each.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         got_q.push_back({out_ch, out_data});
         $display("[%0t] pop ch=%0d data=%h", $time, out_ch, out_data);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req_valid = '0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_scale = '0;
      cfg_shift = '0;
      cfg_zp    = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic cfg_write(input int ch, input logic [15:0] sc, input logic [3:0] sh, input logic [3:0] zp);
      cfg_we    = 1'b1;
      cfg_addr  = ch[1:0];
      cfg_scale = sc;
      cfg_shift = sh;
      cfg_zp    = zp;
      step();
      cfg_we    = 1'b0;
   endtask

   task automatic set_data(input int ch, input logic [14:0] v);
      req_data[15*ch +: 15] = v;
   endtask

   task automatic wait_results(input int n, input int budget);
      for (int c = 0; c < budget; c++) begin
         if (got_q.size() >= n) break;
         step();
      end
   endtask

   task automatic test_reset;
      logic [5:0] g;
      rst = 1'b1;
      idle_inputs();
      req_data  = '0;
      req_valid = 4'hF;
      step();
      step();
      n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL rst_req_ready: got %h expected 0", req_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_cmp++; if ({q_acc, q_scale, q_shift, q_zp} !== 39'h0) begin n_err++; $display("FAIL rst_q_ops: got %h expected 0", {q_acc, q_scale, q_shift, q_zp}); end
      n_cmp++; if ({out_data, out_ch} !== 6'h0) begin n_err++; $display("FAIL rst_out: got %h expected 0", {out_data, out_ch}); end
      req_valid = '0;
      rst = 1'b0;
      step();
      // Untouched table has scale 0, so any accumulator quantizes to 0.
      got_q.delete();
      set_data(1, 15'd100);
      req_valid = 4'b0010;
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rst_first_grant: got %b expected 0010", req_ready); end
      step();
      req_valid = '0;
      wait_results(1, 10);
      g = (got_q.size() > 0) ? got_q[0] : 6'h3F;
      n_cmp++; if (g !== 6'h10) begin n_err++; $display("FAIL rst_table_default: got %h expected 10", g); end
   endtask

   task automatic test_single;
      logic expv;
      do_reset();
      cfg_write(0, 16'd1, 4'd0, 4'd0);
      got_q.delete();
      set_data(0, 15'd3);
      req_valid = 4'b0001;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
      step();
      req_valid = '0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b expected 1", busy); end
      // Grant cycle 0; result visible from cycle LAT+1 (LAT+2 cycles counting the grant cycle).
      for (int c = 1; c <= 3; c++) begin
         expv = (c == 3);
         n_cmp++; if (out_valid !== expv) begin n_err++; $display("FAIL single_latency[c%0d]: got %b expected %b", c, out_valid, expv); end
         if (c < 3) step();
      end
      n_cmp++; if ({out_ch, out_data} !== 6'h03) begin n_err++; $display("FAIL single_result: got %h expected 03", {out_ch, out_data}); end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b expected 0", out_valid); end
      step();
      step();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b expected 0", busy); end
   endtask

   task automatic test_rr;
      logic [3:0] exp_g [5];
      logic [5:0] exp_r [5];
      logic [5:0] g;
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_r = '{6'h01, 6'h12, 6'h23, 6'h34, 6'h01};
      do_reset();
      for (int ch = 0; ch < 4; ch++) cfg_write(ch, 16'd1, 4'd0, 4'd0);
      for (int ch = 0; ch < 4; ch++) set_data(ch, 15'(ch + 1));
      got_q.delete();
      req_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if (req_ready !== exp_g[i]) begin n_err++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, exp_g[i]); end
         step();
      end
      req_valid = '0;
      wait_results(5, 20);
      for (int i = 0; i < 5; i++) begin
         g = (got_q.size() > i) ? got_q[i] : 6'h3F;
         n_cmp++; if (g !== exp_r[i]) begin n_err++; $display("FAIL rr_order[%0d]: got %h expected %h", i, g, exp_r[i]); end
      end
   endtask

   task automatic test_backpressure;
      logic [5:0] g;
      do_reset();
      cfg_write(0, 16'd1, 4'd0, 4'd0);
      got_q.delete();
      out_ready = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         set_data(0, 15'(k + 1));
         #1;
         n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_grant[%0d]: got %b expected 0001", k, req_ready); end
         step();
      end
      set_data(0, 15'd5);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_block[%0d]: got %b expected 0000", k, req_ready); end
         step();
      end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_full_valid: got %b expected 1", out_valid); end
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (req_ready == 4'b0001) break;
         step();
      end
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_resume: got %b expected 0001", req_ready); end
      step();
      req_valid = '0;
      wait_results(5, 20);
      for (int i = 0; i < 5; i++) begin
         g = (got_q.size() > i) ? got_q[i] : 6'h3F;
         n_cmp++; if (g !== 6'(i + 1)) begin n_err++; $display("FAIL bp_order[%0d]: got %h expected %h", i, g, 6'(i + 1)); end
      end
   endtask

   task automatic test_zp_sat;
      logic [5:0] exp_r [4];
      logic [5:0] g;
      exp_r = '{6'h12, 6'h2F, 6'h19, 6'h28};
      do_reset();
      cfg_write(1, 16'd1, 4'd0, 4'd2);
      cfg_write(2, 16'd1, 4'd0, 4'd0);
      got_q.delete();
      set_data(1, 15'd0);
      set_data(2, 15'h7FFF);
      req_valid = 4'b0110;
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL zp_grant1: got %b expected 0010", req_ready); end
      step();
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL zp_grant2: got %b expected 0100", req_ready); end
      step();
      set_data(1, 15'd16383);
      req_valid = 4'b0010;
      step();
      set_data(2, 15'h4000);
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      wait_results(4, 20);
      for (int i = 0; i < 4; i++) begin
         g = (got_q.size() > i) ? got_q[i] : 6'h3F;
         n_cmp++; if (g !== exp_r[i]) begin n_err++; $display("FAIL zp_sat[%0d]: got %h expected %h", i, g, exp_r[i]); end
      end
   endtask

   task automatic test_cfg_hazard;
      logic [5:0] g;
      do_reset();
      cfg_write(3, 16'd1, 4'd0, 4'd0);
      got_q.delete();
      set_data(3, 15'd2);
      req_valid = 4'b1000;
      cfg_we    = 1'b1;
      cfg_addr  = 2'd3;
      cfg_scale = 16'd2;
      cfg_shift = 4'd0;
      cfg_zp    = 4'd0;
      step();
      cfg_we = 1'b0;
      n_cmp++; if (q_scale !== 16'd1) begin n_err++; $display("FAIL hazard_old_scale: got %0d expected 1", q_scale); end
      step();
      req_valid = '0;
      n_cmp++; if (q_scale !== 16'd2) begin n_err++; $display("FAIL hazard_new_scale: got %0d expected 2", q_scale); end
      wait_results(2, 15);
      g = (got_q.size() > 0) ? got_q[0] : 6'h3F;
      n_cmp++; if (g !== 6'h32) begin n_err++; $display("FAIL hazard_res0: got %h expected 32", g); end
      g = (got_q.size() > 1) ? got_q[1] : 6'h3F;
      n_cmp++; if (g !== 6'h34) begin n_err++; $display("FAIL hazard_res1: got %h expected 34", g); end
   endtask

   task automatic test_flush;
      logic [5:0] g;
      do_reset();
      cfg_write(0, 16'd1, 4'd0, 4'd0);
      got_q.delete();
      out_ready = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         set_data(0, 15'(k + 5));
         step();
      end
      req_valid = '0;
      flush = 1'b1;
      step();
      req_valid = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL flush_no_grant[%0d]: got %b expected 0000", c, req_ready); end
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_busy[%0d]: got %b expected 1", c, busy); end
         step();
      end
      out_ready = 1'b1;
      wait_results(3, 15);
      step();
      step();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_held: got %b expected 1", busy); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL flush_held_ready: got %b expected 0000", req_ready); end
      for (int i = 0; i < 3; i++) begin
         g = (got_q.size() > i) ? got_q[i] : 6'h3F;
         n_cmp++; if (g !== 6'(i + 5)) begin n_err++; $display("FAIL flush_order[%0d]: got %h expected %h", i, g, 6'(i + 5)); end
      end
      req_valid = '0;
      flush = 1'b0;
      step();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      cfg_write(0, 16'd1, 4'd0, 4'd0);
      got_q.delete();
      out_ready = 1'b0;
      set_data(0, 15'd6);
      req_valid = 4'b0001;
      step();
      step();
      req_valid = '0;
      repeat (4) step();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
      req_valid = 4'b0001;
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_req_ready: got %b expected 0000", req_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b expected 0", busy); end
      step();
      step();
      req_valid = '0;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (6) step();
      n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL mid_dropped: got %0d expected 0", got_q.size()); end
   endtask

   initial begin
      rst = 1'b1;
      req_data = '0;
      idle_inputs();
      test_reset();
      test_single();
      test_rr();
      test_backpressure();
      test_zp_sat();
      test_cfg_hazard();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
